// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : DES subkey generator: C/D rotate register + combinational PC-2,
//            subkeys issued over valid/ready. DES_KEYSCHED_DECRYPT_EN adds the
//            K16..K1 (right-rotate) order.
// Revision : 1.0
// ============================================================================
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [56:1] key_in,
    input  logic        decrypt,
    output logic [48:1] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_GEN = 1'b1} state_t;

    // PC-2 source bit (table numbering over {C,D}) for output bits 1..48
    localparam logic [47:0][5:0] c_PC2 = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    state_t      r_state, w_state_nxt;
    logic [28:1] r_c, r_d, w_c_nxt, w_d_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic        r_done, w_done_nxt;
    logic        w_dir, w_accept, w_last, w_one;
    logic [56:1] w_cd;

    function automatic logic shift_one(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    function automatic logic [28:1] rotl(input logic [28:1] x, input logic one);
        return one ? {x[27:1], x[28]} : {x[26:1], x[28:27]};
    endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
    logic r_dir, w_dir_nxt;

    function automatic logic [28:1] rotr(input logic [28:1] x, input logic one);
        return one ? {x[1], x[28:2]} : {x[2:1], x[28:3]};
    endfunction

    assign w_dir = r_dir;
    // Decrypt undoes the rotation that produced the current round: shift(R)
    assign w_one = r_dir ? shift_one({1'b0, r_idx} + 5'd1)
                         : shift_one({1'b0, r_idx} + 5'd2);
`else
    logic w_unused;

    assign w_unused = decrypt;
    assign w_dir    = 1'b0;
    assign w_one    = shift_one({1'b0, r_idx} + 5'd2);
`endif

    assign busy         = (r_state == S_GEN);
    assign subkey_valid = busy;
    assign round_idx    = r_idx;
    assign done         = r_done;
    assign w_accept     = subkey_valid & subkey_ready;
    assign w_last       = w_dir ? (r_idx == 4'd0) : (r_idx == 4'd15);
    assign w_cd         = {r_c, r_d};

    for (genvar gi = 1; gi <= 48; gi++) begin : g_pc2
        localparam int c_SRC = 57 - int'(c_PC2[48-gi]);
        assign subkey[49-gi] = w_cd[c_SRC];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
        w_dir_nxt   = r_dir;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_GEN;
                    w_c_nxt     = rotl(key_in[56:29], 1'b1);
                    w_d_nxt     = rotl(key_in[28:1], 1'b1);
                    w_idx_nxt   = 4'd0;
`ifdef DES_KEYSCHED_DECRYPT_EN
                    w_dir_nxt   = decrypt;
                    // Total shift over 16 rounds is 28, so C16/D16 == C0/D0
                    if (decrypt) begin
                        w_c_nxt   = key_in[56:29];
                        w_d_nxt   = key_in[28:1];
                        w_idx_nxt = 4'd15;
                    end
`endif
                end
            end
            S_GEN: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
`ifdef DES_KEYSCHED_DECRYPT_EN
                        if (r_dir) begin
                            w_c_nxt   = rotr(r_c, w_one);
                            w_d_nxt   = rotr(r_d, w_one);
                            w_idx_nxt = r_idx - 4'd1;
                        end else begin
                            w_c_nxt   = rotl(r_c, w_one);
                            w_d_nxt   = rotl(r_d, w_one);
                            w_idx_nxt = r_idx + 4'd1;
                        end
`else
                        w_c_nxt   = rotl(r_c, w_one);
                        w_d_nxt   = rotl(r_d, w_one);
                        w_idx_nxt = r_idx + 4'd1;
`endif
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
`ifdef DES_KEYSCHED_DECRYPT_EN
            r_dir   <= w_dir_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Brief    : Self-checking bench for des_key_schedule (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [56:1] key_in;
    logic        decrypt;
    logic [48:1] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    des_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    typedef struct {
        logic [55:0] key;
        logic        dec;
        logic        use_tab;
        logic [47:0] fill;
        int          stall_after;
        int          stall_len;
        int          poke_at;
        int          reset_at;
        logic        chain;
    } vec_t;

    localparam logic [55:0] c_KEY = 56'hF0CCAAF556678F;

    logic [47:0] ktab [16];
    vec_t        vecs [9];
    exp_t        sb [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every accepted subkey is popped from the scoreboard
    always @(negedge clk) begin
        if (rst_n && subkey_valid && subkey_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_subkey: got %0h, expected none", subkey);
            end else begin
                mon_e = sb.pop_front();
                check("subkey", 64'(subkey), 64'(mon_e.key));
                check("round_idx", 64'(round_idx), 64'(mon_e.idx));
            end
            acc_cnt++;
        end
        if (rst_n && done) begin
            done_cnt++;
            check("busy_at_done", 64'(busy), 64'd0);
            check("done_one_cycle", 64'(prev_done), 64'd0);
        end
        prev_done = done;
    end

    task automatic run_schedule(input vec_t v);
        int   t0;
        int   budget;
        logic rev;
        logic stalled;
        logic poked;
        int   d0;
`ifdef DES_KEYSCHED_DECRYPT_EN
        rev = v.dec;
`else
        rev = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.idx = rev ? 4'(15 - i) : 4'(i);
            e.key = v.use_tab ? ktab[e.idx] : v.fill;
            sb.push_back(e);
        end
        acc_cnt = 0;
        stalled = 1'b0;
        poked   = 1'b0;
        check("idle_before_start", 64'(subkey_valid), 64'd0);
        t0      = cyc;
        start   = 1'b1;
        key_in  = v.key;
        decrypt = v.dec;
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = {24'($urandom), 32'($urandom)};
        decrypt = 1'($urandom);
        check("first_valid", 64'(subkey_valid), 64'd1);
        check("first_idx", 64'(round_idx), rev ? 64'd15 : 64'd0);
        budget = 0;
        while (!done && budget < 80) begin
            if (v.stall_len > 0 && !stalled && acc_cnt == v.stall_after) begin
                subkey_ready = 1'b0;
                for (int k = 0; k < v.stall_len; k++) begin
                    @(negedge clk);
                    check("stall_subkey", 64'(subkey), 64'(sb[0].key));
                    check("stall_idx", 64'(round_idx), 64'(v.stall_after));
                    @(posedge clk); #1;
                end
                subkey_ready = 1'b1;
                stalled      = 1'b1;
            end else if (v.poke_at >= 0 && !poked && acc_cnt == v.poke_at) begin
                start   = 1'b1;
                key_in  = '0;
                decrypt = ~v.dec;
                @(posedge clk); #1;
                start   = 1'b0;
                poked   = 1'b1;
            end else if (v.reset_at >= 0 && acc_cnt == v.reset_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                sb.delete();
                @(negedge clk);
                check("rst_valid", 64'(subkey_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_subkey", 64'(subkey), 64'd0);
                check("rst_idx", 64'(round_idx), 64'd0);
                d0 = done_cnt;
                repeat (20) @(posedge clk);
                #1;
                check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
                return;
            end else begin
                @(posedge clk); #1;
            end
            budget++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done by cycle %0d", t0 + 17 + v.stall_len);
        end else begin
            check("done_cycle", 64'(cyc - t0), 64'(17 + v.stall_len));
            check("sb_drained", 64'(sb.size()), 64'd0);
        end
    endtask

    initial begin
        ktab[0]  = 48'h1B02EFFC7072;  ktab[1]  = 48'h79AED9DBC9E5;
        ktab[2]  = 48'h55FC8A42CF99;  ktab[3]  = 48'h72ADD6DB351D;
        ktab[4]  = 48'h7CEC07EB53A8;  ktab[5]  = 48'h63A53E507B2F;
        ktab[6]  = 48'hEC84B7F618BC;  ktab[7]  = 48'hF78A3AC13BFB;
        ktab[8]  = 48'hE0DBEBEDE781;  ktab[9]  = 48'hB1F347BA464F;
        ktab[10] = 48'h215FD3DED386;  ktab[11] = 48'h7571F59467E9;
        ktab[12] = 48'h97C5D1FABA41;  ktab[13] = 48'h5F43B7F2E73A;
        ktab[14] = 48'hBF918D3D3F0A;  ktab[15] = 48'hCB3D8B0E17F5;

        //            key            dec   tab   fill        stall  len poke rst chain
        vecs[0] = '{c_KEY,           1'b0, 1'b1, 48'h0,       -1, 0, -1, -1, 1'b0};
        vecs[1] = '{c_KEY,           1'b1, 1'b1, 48'h0,       -1, 0, -1, -1, 1'b0};
        vecs[2] = '{c_KEY,           1'b0, 1'b1, 48'h0,        2, 5, -1, -1, 1'b0};
        vecs[3] = '{c_KEY,           1'b0, 1'b1, 48'h0,       -1, 0,  7, -1, 1'b0};
        vecs[4] = '{c_KEY,           1'b0, 1'b1, 48'h0,       -1, 0, -1,  9, 1'b0};
        vecs[5] = '{c_KEY,           1'b0, 1'b1, 48'h0,       -1, 0, -1, -1, 1'b1};
        vecs[6] = '{c_KEY,           1'b1, 1'b1, 48'h0,       -1, 0, -1, -1, 1'b0};
        vecs[7] = '{56'h0,           1'b0, 1'b0, 48'h0,       -1, 0, -1, -1, 1'b0};
        vecs[8] = '{56'hFFFFFFFFFFFFFF, 1'b1, 1'b0, 48'hFFFFFFFFFFFF, -1, 0, -1, -1, 1'b0};

        rst_n        = 1'b0;
        start        = 1'b0;
        key_in       = '0;
        decrypt      = 1'b0;
        subkey_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(subkey_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_subkey", 64'(subkey), 64'd0);
        check("reset_idx", 64'(round_idx), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 9; r++) begin
            run_schedule(vecs[r]);
            if (!vecs[r].chain) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_idle_busy", 64'(busy), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
